// File: rtl/cfg_write_arbiter.sv
// rtl/cfg_write_arbiter.sv - Boot-loaded config register bank with two-requester write arbitration
// Requests that arrive during boot stay pending and are served once the bank reaches IDLE.
module cfg_write_arbiter #(
  parameter int NUM_REGS = 5,
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8,
  parameter bit RR       = 1'b1,
  parameter logic [NUM_REGS*DATA_W-1:0] INIT_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       a_req,
  input  logic [ADDR_W-1:0]          a_addr,
  input  logic [DATA_W-1:0]          a_data,
  output logic                       a_ack,
  output logic                       a_err,
  input  logic                       b_req,
  input  logic [ADDR_W-1:0]          b_addr,
  input  logic [DATA_W-1:0]          b_data,
  output logic                       b_ack,
  output logic                       b_err,
  output logic                       busy,
  output logic                       cfg_update,
  output logic [ADDR_W-1:0]          upd_addr,
  output logic [NUM_REGS*DATA_W-1:0] reg_out
);

  typedef enum logic [1:0] {BOOT, IDLE, GRANT, HOLD} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   cnt;
  logic [ADDR_W-1:0]   hold_addr;
  logic [DATA_W-1:0]   hold_data;
  logic                sel_b;
  logic                last_b;
  logic                pick_b;
  logic                addr_ok;
  logic                win_req;
  logic                boot_last;

  // On a tie, round-robin serves whichever port did not win last time.
  always_comb begin
    pick_b = b_req;
    if (a_req && b_req) pick_b = RR ? ~last_b : 1'b0;
  end

  assign addr_ok   = (hold_addr < ADDR_W'(NUM_REGS));
  assign win_req   = sel_b ? b_req : a_req;
  assign boot_last = (cnt == ADDR_W'(NUM_REGS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= BOOT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      BOOT:    if (boot_last) state_nxt = IDLE;
      IDLE:    if (a_req || b_req) state_nxt = GRANT;
      GRANT:   state_nxt = HOLD;
      HOLD:    if (!win_req) state_nxt = IDLE;
      default: state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_out    <= '0;
      a_ack      <= 1'b0;
      b_ack      <= 1'b0;
      a_err      <= 1'b0;
      b_err      <= 1'b0;
      cfg_update <= 1'b0;
      upd_addr   <= '0;
      busy       <= 1'b1;
      cnt        <= '0;
      hold_addr  <= '0;
      hold_data  <= '0;
      sel_b      <= 1'b0;
      last_b     <= 1'b1;
    end else begin
      cfg_update <= 1'b0;
      case (state)
        BOOT: begin
          for (int i = 0; i < NUM_REGS; i++)
            if (cnt == ADDR_W'(i)) reg_out[i*DATA_W +: DATA_W] <= INIT_VAL[i*DATA_W +: DATA_W];
          cfg_update <= 1'b1;
          upd_addr   <= cnt;
          cnt        <= cnt + 1'b1;
          if (boot_last) busy <= 1'b0;
        end
        IDLE: begin
          if (a_req || b_req) begin
            hold_addr <= pick_b ? b_addr : a_addr;
            hold_data <= pick_b ? b_data : a_data;
            sel_b     <= pick_b;
            last_b    <= pick_b;
          end
        end
        GRANT: begin
          // Out-of-range addresses are rejected whole, never folded into the bank.
          if (addr_ok) begin
            for (int i = 0; i < NUM_REGS; i++)
              if (hold_addr == ADDR_W'(i)) reg_out[i*DATA_W +: DATA_W] <= hold_data;
            cfg_update <= 1'b1;
            upd_addr   <= hold_addr;
          end
          a_ack <= ~sel_b;
          b_ack <= sel_b;
          a_err <= ~sel_b & ~addr_ok;
          b_err <= sel_b & ~addr_ok;
        end
        HOLD: begin
          if (!win_req) begin
            a_ack <= 1'b0;
            b_ack <= 1'b0;
            a_err <= 1'b0;
            b_err <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cfg_write_arbiter.sv
// tb/tb_cfg_write_arbiter.sv - Directed self-checking bench for cfg_write_arbiter
// Two instances share inputs: r_* is round-robin with boot defaults, f_* is fixed priority.
module tb_cfg_write_arbiter;
  localparam int NR = 5;
  localparam int AW = 7;
  localparam int DW = 8;
  localparam logic [NR*DW-1:0] INIT = 40'h55_44_33_22_11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic a_req = 1'b0, b_req = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_data = '0, b_data = '0;

  logic r_a_ack, r_a_err, r_b_ack, r_b_err, r_busy, r_upd;
  logic [AW-1:0] r_upd_addr;
  logic [NR*DW-1:0] r_reg_out;
  logic f_a_ack, f_a_err, f_b_ack, f_b_err, f_busy, f_upd;
  logic [AW-1:0] f_upd_addr;
  logic [NR*DW-1:0] f_reg_out;

  int checks = 0;
  int failures = 0;
  logic [NR*DW-1:0] exp_r;

  always #5 clk = ~clk;

  cfg_write_arbiter #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW), .RR(1'b1), .INIT_VAL(INIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_addr(a_addr), .a_data(a_data), .a_ack(r_a_ack), .a_err(r_a_err),
    .b_req(b_req), .b_addr(b_addr), .b_data(b_data), .b_ack(r_b_ack), .b_err(r_b_err),
    .busy(r_busy), .cfg_update(r_upd), .upd_addr(r_upd_addr), .reg_out(r_reg_out));

  cfg_write_arbiter #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW), .RR(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_addr(a_addr), .a_data(a_data), .a_ack(f_a_ack), .a_err(f_a_err),
    .b_req(b_req), .b_addr(b_addr), .b_data(b_data), .b_ack(f_b_ack), .b_err(f_b_err),
    .busy(f_busy), .cfg_update(f_upd), .upd_addr(f_upd_addr), .reg_out(f_reg_out));

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_ack(input bit fixed, input bit want_b, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (want_b ? (fixed ? f_b_ack : r_b_ack) : (fixed ? f_a_ack : r_a_ack)) seen = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; a_req = 1'b1; a_addr = 7'd3; a_data = 8'h77;
    repeat (3) @(negedge clk);
    checks++; if (r_reg_out !== '0) begin failures++; $display("FAIL reset_regs got=%h exp=0", r_reg_out); end
    checks++; if (r_busy !== 1'b1) begin failures++; $display("FAIL reset_busy got=%b exp=1", r_busy); end
    checks++; if (r_a_ack !== 1'b0 || r_b_ack !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b%b exp=00", r_a_ack, r_b_ack); end
    checks++; if (r_upd !== 1'b0 || r_upd_addr !== '0) begin failures++; $display("FAIL reset_upd got=%b/%h exp=0/0", r_upd, r_upd_addr); end
  endtask

  task automatic test_boot;
    rst_n = 1'b1;
    for (int k = 1; k <= NR; k++) begin
      @(negedge clk);
      checks++; if (r_upd !== 1'b1 || r_upd_addr !== AW'(k-1)) begin failures++; $display("FAIL boot_upd k=%0d got=%b/%h exp=1/%h", k, r_upd, r_upd_addr, k-1); end
      checks++; if (r_busy !== (k < NR)) begin failures++; $display("FAIL boot_busy k=%0d got=%b exp=%b", k, r_busy, k < NR); end
      checks++; if (r_a_ack !== 1'b0) begin failures++; $display("FAIL boot_ack_early k=%0d got=%b exp=0", k, r_a_ack); end
    end
    exp_r = INIT;
    checks++; if (r_reg_out !== exp_r) begin failures++; $display("FAIL boot_regs got=%h exp=%h", r_reg_out, exp_r); end
    @(negedge clk);
    checks++; if (r_a_ack !== 1'b0 || r_upd !== 1'b0) begin failures++; $display("FAIL boot_capture got=%b/%b exp=0/0", r_a_ack, r_upd); end
    @(negedge clk);
    exp_r[3*DW +: DW] = 8'h77;
    checks++; if (r_a_ack !== 1'b1 || r_reg_out !== exp_r) begin failures++; $display("FAIL boot_pending got=%b/%h exp=1/%h", r_a_ack, r_reg_out, exp_r); end
    checks++; if (r_upd !== 1'b1 || r_upd_addr !== 7'd3) begin failures++; $display("FAIL boot_pending_upd got=%b/%h exp=1/3", r_upd, r_upd_addr); end
    a_req = 1'b0;
    @(negedge clk);
    checks++; if (r_a_ack !== 1'b0) begin failures++; $display("FAIL boot_release got=%b exp=0", r_a_ack); end
  endtask

  task automatic test_write;
    a_req = 1'b1; a_addr = 7'd2; a_data = 8'hA5;
    @(negedge clk);
    checks++; if (r_a_ack !== 1'b0 || r_upd !== 1'b0) begin failures++; $display("FAIL write_early got=%b/%b exp=0/0", r_a_ack, r_upd); end
    @(negedge clk);
    exp_r[2*DW +: DW] = 8'hA5;
    checks++; if (r_a_ack !== 1'b1 || r_a_err !== 1'b0) begin failures++; $display("FAIL write_ack got=%b/%b exp=1/0", r_a_ack, r_a_err); end
    checks++; if (r_reg_out !== exp_r) begin failures++; $display("FAIL write_regs got=%h exp=%h", r_reg_out, exp_r); end
    checks++; if (r_upd !== 1'b1 || r_upd_addr !== 7'd2) begin failures++; $display("FAIL write_upd got=%b/%h exp=1/2", r_upd, r_upd_addr); end
    @(negedge clk);
    checks++; if (r_a_ack !== 1'b1 || r_upd !== 1'b0) begin failures++; $display("FAIL write_hold got=%b/%b exp=1/0", r_a_ack, r_upd); end
    a_req = 1'b0;
    @(negedge clk);
    checks++; if (r_a_ack !== 1'b0) begin failures++; $display("FAIL write_release got=%b exp=0", r_a_ack); end
  endtask

  task automatic test_bad_addr;
    logic [AW-1:0] bad [2];
    bad[0] = 7'd5; bad[1] = 7'h7F;
    for (int j = 0; j < 2; j++) begin
      a_req = 1'b1; a_addr = bad[j]; a_data = 8'hEE;
      @(negedge clk);
      @(negedge clk);
      checks++; if (r_a_ack !== 1'b1 || r_a_err !== 1'b1) begin failures++; $display("FAIL err_ack addr=%h got=%b/%b exp=1/1", bad[j], r_a_ack, r_a_err); end
      checks++; if (r_upd !== 1'b0 || r_reg_out !== exp_r) begin failures++; $display("FAIL err_nowrite addr=%h got=%b/%h exp=0/%h", bad[j], r_upd, r_reg_out, exp_r); end
      a_req = 1'b0;
      @(negedge clk);
      checks++; if (r_a_ack !== 1'b0 || r_a_err !== 1'b0) begin failures++; $display("FAIL err_release addr=%h got=%b/%b exp=0/0", bad[j], r_a_ack, r_a_err); end
    end
  endtask

  task automatic test_b_write;
    bit seen;
    b_req = 1'b1; b_addr = 7'd4; b_data = 8'h5A;
    wait_ack(1'b0, 1'b1, seen);
    exp_r[4*DW +: DW] = 8'h5A;
    checks++; if (!seen || r_b_err !== 1'b0 || r_a_ack !== 1'b0) begin failures++; $display("FAIL b_write_ack got=%b/%b/%b exp=1/0/0", seen, r_b_err, r_a_ack); end
    checks++; if (r_reg_out !== exp_r) begin failures++; $display("FAIL b_write_regs got=%h exp=%h", r_reg_out, exp_r); end
    b_req = 1'b0;
    @(negedge clk);
    checks++; if (r_b_ack !== 1'b0) begin failures++; $display("FAIL b_write_release got=%b exp=0", r_b_ack); end
  endtask

  // Tie, then A re-requests at once while B waits: round-robin must serve B next, fixed serves A again.
  task automatic test_arbitration(input bit fixed);
    bit seen;
    logic [NR*DW-1:0] ro;
    a_req = 1'b1; a_addr = 7'd0; a_data = 8'h01;
    b_req = 1'b1; b_addr = 7'd1; b_data = 8'h02;
    wait_ack(fixed, 1'b0, seen);
    ro = fixed ? f_reg_out : r_reg_out;
    checks++; if (!seen || (fixed ? f_b_ack : r_b_ack) !== 1'b0 || ro[0 +: DW] !== 8'h01) begin failures++; $display("FAIL arb_first fixed=%b got=%b/%h exp=1/01", fixed, seen, ro[0 +: DW]); end
    a_req = 1'b0;
    @(negedge clk);
    checks++; if ((fixed ? f_a_ack : r_a_ack) !== 1'b0) begin failures++; $display("FAIL arb_first_release fixed=%b got=1 exp=0", fixed); end
    a_req = 1'b1; a_data = 8'h03;
    wait_ack(fixed, !fixed, seen);
    ro = fixed ? f_reg_out : r_reg_out;
    if (fixed) begin
      checks++; if (!seen || f_b_ack !== 1'b0 || ro[0 +: DW] !== 8'h03) begin failures++; $display("FAIL arb_second_fixed got=%b/%b/%h exp=1/0/03", seen, f_b_ack, ro[0 +: DW]); end
      a_req = 1'b0;
    end else begin
      checks++; if (!seen || r_a_ack !== 1'b0 || ro[DW +: DW] !== 8'h02) begin failures++; $display("FAIL arb_second_rr got=%b/%b/%h exp=1/0/02", seen, r_a_ack, ro[DW +: DW]); end
      b_req = 1'b0;
    end
    wait_ack(fixed, fixed, seen);
    ro = fixed ? f_reg_out : r_reg_out;
    checks++; if (!seen || ro[0 +: 2*DW] !== 16'h0203) begin failures++; $display("FAIL arb_third fixed=%b got=%b/%h exp=1/0203", fixed, seen, ro[0 +: 2*DW]); end
    a_req = 1'b0; b_req = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if ((fixed ? (f_a_ack | f_b_ack) : (r_a_ack | r_b_ack)) !== 1'b0) begin failures++; $display("FAIL arb_idle fixed=%b got=1 exp=0", fixed); end
  endtask

  task automatic test_reset_mid;
    bit seen;
    b_req = 1'b1; b_addr = 7'd2; b_data = 8'h66;
    wait_ack(1'b0, 1'b1, seen);
    checks++; if (!seen) begin failures++; $display("FAIL mid_hold got=0 exp=1"); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (r_b_ack !== 1'b0 || r_reg_out !== '0 || r_busy !== 1'b1) begin failures++; $display("FAIL mid_reset got=%b/%h/%b exp=0/0/1", r_b_ack, r_reg_out, r_busy); end
    b_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (NR - 1) @(negedge clk);
    checks++; if (r_busy !== 1'b1) begin failures++; $display("FAIL mid_reboot_busy got=%b exp=1", r_busy); end
    @(negedge clk);
    exp_r = INIT;
    checks++; if (r_busy !== 1'b0 || r_reg_out !== exp_r) begin failures++; $display("FAIL mid_reboot got=%b/%h exp=0/%h", r_busy, r_reg_out, exp_r); end
  endtask

  task automatic test_capture;
    a_req = 1'b1; a_addr = 7'd1; a_data = 8'h10;
    @(negedge clk);
    a_data = 8'h20; a_req = 1'b0;
    checks++; if (r_a_ack !== 1'b0) begin failures++; $display("FAIL cap_early got=%b exp=0", r_a_ack); end
    @(negedge clk);
    exp_r[DW +: DW] = 8'h10;
    checks++; if (r_a_ack !== 1'b1 || r_reg_out !== exp_r || r_upd !== 1'b1) begin failures++; $display("FAIL cap_write got=%b/%h/%b exp=1/%h/1", r_a_ack, r_reg_out, r_upd, exp_r); end
    @(negedge clk);
    checks++; if (r_a_ack !== 1'b0) begin failures++; $display("FAIL cap_short_ack got=%b exp=0", r_a_ack); end
  endtask

  initial begin
    test_reset;
    test_boot;
    test_write;
    test_bad_addr;
    test_b_write;
    test_arbitration(1'b0);
    test_reset_mid;
    test_capture;
    test_arbitration(1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
